uart_rx_control: RTL and testbench

- Receive-side front end of the serial link.
- Synchronises the raw rx line and detects the start bit using an oversampling baud tick.
- Samples each data bit at mid-bit and drives a serial bit plus a one-cycle enable to the downstream 8-bit serial-to-parallel stage.
- Also assembles the byte internally (LSB-first), checks the stop bit and flags a completed or errored frame.

---
 rtl/uart_rx_control.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_control.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_control.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_control
// Purpose  : Receive-side front end of the serial link. Synchronises the raw
//            rx line, detects the start bit with an oversampling baud tick,
//            samples each data bit at mid-bit and forwards it (bit + one-clk
//            enable) to the downstream serial-to-parallel stage. The byte is
//            also assembled locally (LSB first) and the stop bit is checked.
// Ports    :
//   clk         in   1  system clock
//   rst         in   1  synchronous, active-high reset
//   baud_tick   in   1  one-clk pulse, OVERSAMPLE pulses per bit period
//   rx          in   1  asynchronous serial line, idle high
//   sample_bit  out  1  value of the bit just sampled (held between pulses)
//   sample_en   out  1  one-clk pulse per data bit
//   rx_data     out  8  last good byte, unused upper bits 0
//   rx_valid    out  1  one-clk pulse: good frame, rx_data updated
//   frame_err   out  1  one-clk pulse: stop bit sampled low
//   busy        out  1  high while a frame is in progress
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_control #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx,
  output logic       sample_bit,
  output logic       sample_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  // Bits enter at the MSB of the shift register, so a short frame ends up
  // left-aligned and must be shifted down into the low bits.
  localparam int            ALIGN    = 8 - DATA_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // rx synchroniser: reset to the idle level so no false start after reset
  // --------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // --------------------------------------------------------------------------
  // Frame state and datapath registers
  // --------------------------------------------------------------------------
  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   tick_cnt;
  logic [TW-1:0]   tick_nxt;
  logic [BW-1:0]   bit_cnt;
  logic [BW-1:0]   bit_nxt;
  logic [BW-1:0]   bit_inc;
  logic [7:0]      shift;
  logic [7:0]      shift_nxt;
  logic            break_wait;
  logic            break_nxt;
  logic            sbit_nxt;
  logic            en_nxt;
  logic [7:0]      data_nxt;
  logic            valid_nxt;
  logic            ferr_nxt;

  assign bit_inc = bit_cnt + BIT_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      break_wait <= 1'b0;
      sample_bit <= 1'b0;
      sample_en  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      tick_cnt   <= tick_nxt;
      bit_cnt    <= bit_nxt;
      shift      <= shift_nxt;
      break_wait <= break_nxt;
      sample_bit <= sbit_nxt;
      sample_en  <= en_nxt;
      rx_data    <= data_nxt;
      rx_valid   <= valid_nxt;
      frame_err  <= ferr_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic. Nothing moves unless baud_tick is high.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    break_nxt = break_wait;
    sbit_nxt  = sample_bit;
    data_nxt  = rx_data;
    en_nxt    = 1'b0;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;

    if (baud_tick) begin
      case (state)
        IDLE: begin
          // After a framing error the line may be held low (break); the
          // line must be seen high once before a new start is accepted.
          if (break_wait) begin
            if (rx_s) begin
              break_nxt = 1'b0;
            end
          end else if (!rx_s) begin
            state_nxt = START;
            tick_nxt  = '0;
          end
        end

        START: begin
          if (tick_cnt == TICK_MID) begin
            tick_nxt = '0;
            if (rx_s) begin
              // Line went back high before mid-bit: treat as a glitch.
              state_nxt = IDLE;
            end else begin
              state_nxt = DATA;
              bit_nxt   = '0;
            end
          end else begin
            tick_nxt = tick_cnt + TICK_ONE;
          end
        end

        DATA: begin
          if (tick_cnt == TICK_END) begin
            tick_nxt  = '0;
            sbit_nxt  = rx_s;
            en_nxt    = 1'b1;
            shift_nxt = {rx_s, shift[7:1]};
            bit_nxt   = bit_inc;
            if (bit_inc == BIT_LAST) begin
              state_nxt = STOP;
            end
          end else begin
            tick_nxt = tick_cnt + TICK_ONE;
          end
        end

        STOP: begin
          if (tick_cnt == TICK_END) begin
            tick_nxt  = '0;
            state_nxt = IDLE;
            if (rx_s) begin
              data_nxt  = shift >> ALIGN;
              valid_nxt = 1'b1;
            end else begin
              ferr_nxt  = 1'b1;
              break_nxt = 1'b1;
            end
          end else begin
            tick_nxt = tick_cnt + TICK_ONE;
          end
        end

        default: begin
          state_nxt = IDLE;
          tick_nxt  = '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_control
// Purpose  : Self-checking bench for uart_rx_control. Frames are driven on
//            the rx line one bit period at a time; a frame-level model
//            predicts the sampled bit stream, received bytes, framing
//            errors and end-of-frame latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_control;

  localparam int OS       = 16;
  localparam int DB       = 8;
  localparam int TICK_DIV = 4;
  // Start is driven right after a tick; the synchroniser settles before the
  // next tick, so detection happens one tick later. Stop is sampled
  // (DB+1)*OS + OS/2 ticks after detection and shows up one clk later,
  // which is the cycle the monitor samples on its negedge.
  localparam int LAT      = ((DB + 1) * OS + OS / 2 + 1) * TICK_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       rx;
  logic       sample_bit;
  logic       sample_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx_control #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_tick  (baud_tick),
    .rx         (rx),
    .sample_bit (sample_bit),
    .sample_en  (sample_en),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Baud tick: one clk high out of every TICK_DIV
  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(posedge clk);
      #1 baud_tick = 1'b1;
      @(posedge clk);
      #1 baud_tick = 1'b0;
    end
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  int         total = 0;
  int         bad   = 0;
  logic       act_bits[$];
  logic [7:0] act_bytes[$];
  int         act_lat[$];
  int         act_ferr = 0;
  int         viol = 0;
  int         start_cyc = 0;

  logic       exp_bits[$];
  logic [7:0] exp_bytes[$];
  int         exp_ferr = 0;
  int         exp_ends = 0;
  logic [7:0] last_good = 8'h00;

  // Monitor: collect events and watch pulse width / exclusivity
  initial begin
    logic p_en, p_v, p_f;
    p_en = 1'b0; p_v = 1'b0; p_f = 1'b0;
    forever begin
      @(negedge clk);
      if (sample_en === 1'b1) act_bits.push_back(sample_bit);
      if (rx_valid === 1'b1) begin
        act_bytes.push_back(rx_data);
        act_lat.push_back(cyc - start_cyc);
      end
      if (frame_err === 1'b1) begin
        act_ferr++;
        act_lat.push_back(cyc - start_cyc);
      end
      if ((int'(sample_en === 1'b1) + int'(rx_valid === 1'b1) + int'(frame_err === 1'b1)) > 1) viol++;
      if ((sample_en === 1'b1 && p_en) || (rx_valid === 1'b1 && p_v) || (frame_err === 1'b1 && p_f)) viol++;
      p_en = (sample_en === 1'b1);
      p_v  = (rx_valid === 1'b1);
      p_f  = (frame_err === 1'b1);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame-level reference: what a frame of nbits data bits should produce
  function automatic void model_frame(input logic [7:0] b, input logic stop, input int nbits);
    for (int i = 0; i < nbits; i++) exp_bits.push_back(b[i]);
    if (nbits == DB) begin
      exp_ends++;
      if (stop) begin
        exp_bytes.push_back(b);
        last_good = b;
      end else begin
        exp_ferr++;
      end
    end
  endfunction

  // Advance to just after the next tick edge
  task automatic tick();
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      guard++;
    end while (baud_tick !== 1'b1 && guard < 4 * TICK_DIV);
    #1;
  endtask

  task automatic drive(input logic v, input int nticks);
    rx = v;
    for (int i = 0; i < nticks; i++) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int nbits);
    start_cyc = cyc;
    drive(1'b0, OS);
    for (int i = 0; i < nbits; i++) drive(b[i], OS);
    if (nbits == DB) drive(stop, OS);
    model_frame(b, stop, nbits);
  endtask

  task automatic compare(input string tag);
    int n;
    check({tag, "_nbits"}, act_bits.size(), exp_bits.size());
    n = (act_bits.size() < exp_bits.size()) ? act_bits.size() : exp_bits.size();
    for (int i = 0; i < n; i++) check({tag, "_bit"}, act_bits[i], exp_bits[i]);
    check({tag, "_nbytes"}, act_bytes.size(), exp_bytes.size());
    n = (act_bytes.size() < exp_bytes.size()) ? act_bytes.size() : exp_bytes.size();
    for (int i = 0; i < n; i++) check({tag, "_byte"}, act_bytes[i], exp_bytes[i]);
    check({tag, "_ferr"}, act_ferr, exp_ferr);
    check({tag, "_nends"}, act_lat.size(), exp_ends);
    foreach (act_lat[i]) check({tag, "_lat"}, act_lat[i], LAT);
    check({tag, "_rx_data"}, rx_data, last_good);
    check({tag, "_busy"}, busy, 1'b0);
    act_bits.delete(); exp_bits.delete();
    act_bytes.delete(); exp_bytes.delete();
    act_lat.delete();
    act_ferr = 0; exp_ferr = 0; exp_ends = 0;
  endtask

  initial begin
    logic [7:0] b;
    logic       stop;
    logic       prev_bad;
    int         gap;

    // Reset held with the line low
    rst = 1'b1;
    rx  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sample_bit", sample_bit, 1'b0);
    check("rst_sample_en", sample_en, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    rx  = 1'b1;
    tick();
    drive(1'b1, 40);
    compare("idle");

    // Directed good frame
    send_frame(8'hA5, 1'b1, DB);
    drive(1'b1, 4);
    compare("a5");

    // Short low glitch aborts at mid start bit
    drive(1'b0, 4);
    drive(1'b1, 12);
    compare("glitch");

    // Framing error with the line then held low (break)
    send_frame(8'h3C, 1'b0, DB);
    drive(1'b0, 40);
    compare("ferr");
    drive(1'b1, 4);

    // Reset after four data bits, then a clean frame
    b = 8'($urandom()) | 8'h08;
    send_frame(b, 1'b1, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_sample_bit", sample_bit, 1'b0);
    check("mid_rst_sample_en", sample_en, 1'b0);
    check("mid_rst_rx_data", rx_data, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    rst = 1'b0;
    rx  = 1'b1;
    last_good = 8'h00;
    tick();
    drive(1'b1, 4);
    send_frame(8'h81, 1'b1, DB);
    drive(1'b1, 4);
    compare("midrst");

    // Back-to-back frames with no idle gap
    send_frame(8'h00, 1'b1, DB);
    send_frame(8'hFF, 1'b1, DB);
    drive(1'b1, 4);
    compare("b2b");

    // Randomized traffic
    prev_bad = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, $urandom_range(1, 8));
        drive(1'b1, 10);
        prev_bad = 1'b0;
      end
      b    = 8'($urandom());
      stop = ($urandom_range(0, 3) != 0);
      gap  = prev_bad ? $urandom_range(1, 3) : $urandom_range(0, 3);
      if (gap > 0) drive(1'b1, gap);
      send_frame(b, stop, DB);
      prev_bad = !stop;
    end
    drive(1'b1, 6);
    compare("rand");

    check("pulse_rules", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
